uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_sync.sv | 22 ++
 rtl/uart_rx.sv | 151 +++++++++++++++
 tb/tb_uart_rx.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default bit period (100 MHz / 115200 baud).
package uart_pkg;

    localparam int UART_CLKS_PER_BIT = 868;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START      = 3'd1,
        DATA       = 3'd2,
        PARITY     = 3'd3,
        STOP       = 3'd4,
        BREAK_WAIT = 3'd5
    } uart_state_e;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle level (1).
// Latency 2 cycles; no backpressure.
module uart_sync (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1 (8E1 with UART_RX_PARITY_EN); rx_done 3 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT
// cycles after the start edge (+CLKS_PER_BIT with parity). No backpressure: each frame yields one pulse.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_data_in,
    output logic [7:0] rx_byte,
    output logic       rx_done,
    output logic       rx_active,
    output logic       rx_frame_err,
    output logic       rx_parity_err
);

    localparam int            CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);

    logic        rx_s;
    uart_state_e state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]  bit_idx_q;
    logic [7:0]  shift_q;
    logic [7:0]  rx_byte_q;
    logic        load_q;
    logic        done_q;
    logic        ferr_q;
`ifdef UART_RX_PARITY_EN
    logic        par_ok_q;
    logic        perr_q;
`endif

    uart_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (rx_data_in),
        .q_o (rx_s)
    );

    // A good stop sample only arms load_q; rx_byte and rx_done update one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            rx_byte_q <= '0;
            load_q    <= 1'b0;
            done_q    <= 1'b0;
            ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_ok_q  <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            done_q <= load_q;
            load_q <= 1'b0;
            ferr_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q <= 1'b0;
`endif
            if (load_q) begin
                rx_byte_q <= shift_q;
            end
            cnt_q <= cnt_q + 1'b1;

            case (state_q)
                IDLE: begin
                    cnt_q     <= '0;
                    bit_idx_q <= '0;
                    if (!rx_s) begin
                        state_q <= START;
                    end
                end
                START: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_q   <= '0;
                        state_q <= rx_s ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (cnt_q == FULL_LAST) begin
                        cnt_q     <= '0;
                        shift_q   <= {rx_s, shift_q[7:1]};
                        bit_idx_q <= bit_idx_q + 1'b1;
                        if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= PARITY;
`else
                            state_q <= STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (cnt_q == FULL_LAST) begin
                        cnt_q    <= '0;
                        par_ok_q <= (rx_s == ^shift_q);
                        state_q  <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (cnt_q == FULL_LAST) begin
                        cnt_q <= '0;
                        if (rx_s) begin
`ifdef UART_RX_PARITY_EN
                            if (par_ok_q) begin
                                load_q <= 1'b1;
                            end else begin
                                perr_q <= 1'b1;
                            end
`else
                            load_q <= 1'b1;
`endif
                            state_q <= IDLE;
                        end else begin
                            ferr_q  <= 1'b1;
                            state_q <= BREAK_WAIT;
                        end
                    end
                end
                BREAK_WAIT: begin
                    cnt_q <= '0;
                    if (rx_s) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    cnt_q   <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rx_byte      = rx_byte_q;
    assign rx_done      = done_q;
    assign rx_active    = (state_q != IDLE);
    assign rx_frame_err = ferr_q;
`ifdef UART_RX_PARITY_EN
    assign rx_parity_err = perr_q;
`else
    assign rx_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a fast instance (32 clks/bit) for most scenarios and a
// default-rate instance (868 clks/bit) for the reference latency and glitch rejection.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int CPB   = 32;
    localparam int CPB_F = 868;
`ifdef UART_RX_PARITY_EN
    localparam int LAT   = 339;   // 3 + 16 + 10*32
    localparam int LAT_F = 9117;  // 3 + 434 + 10*868
`else
    localparam int LAT   = 307;   // 3 + 16 + 9*32
    localparam int LAT_F = 8249;  // 3 + 434 + 9*868
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       rx, rx_f;
    logic [7:0] rx_byte, rx_byte_f;
    logic       rx_done, rx_active, rx_frame_err, rx_parity_err;
    logic       rx_done_f, rx_active_f, rx_frame_err_f, rx_parity_err_f;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int done_cnt, ferr_cnt, perr_cnt, done_cyc, start_cyc;
    int done_cnt_f, ferr_cnt_f, done_cyc_f, start_cyc_f;
    int perr_total = 0;
    int excl_viol  = 0;
    int width_viol = 0;
    logic [7:0] byteq[$];
    logic [7:0] byte_last_f;
    logic [2:0] prev_p   = '0;
    logic [2:0] prev_p_f = '0;

    uart_rx #(.CLKS_PER_BIT(CPB)) u_dut (
        .clk           (clk),
        .rst           (rst),
        .rx_data_in    (rx),
        .rx_byte       (rx_byte),
        .rx_done       (rx_done),
        .rx_active     (rx_active),
        .rx_frame_err  (rx_frame_err),
        .rx_parity_err (rx_parity_err)
    );

    uart_rx u_dut_full (
        .clk           (clk),
        .rst           (rst),
        .rx_data_in    (rx_f),
        .rx_byte       (rx_byte_f),
        .rx_done       (rx_done_f),
        .rx_active     (rx_active_f),
        .rx_frame_err  (rx_frame_err_f),
        .rx_parity_err (rx_parity_err_f)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse bookkeeping, sampled on the falling edge.
    always @(negedge clk) begin
        logic [2:0] cur, cur_f;
        cur   = {rx_done, rx_frame_err, rx_parity_err};
        cur_f = {rx_done_f, rx_frame_err_f, rx_parity_err_f};
        if (rx_done) begin
            done_cnt++;
            byteq.push_back(rx_byte);
            done_cyc = cyc;
        end
        if (rx_frame_err)  ferr_cnt++;
        if (rx_parity_err) begin
            perr_cnt++;
            perr_total++;
        end
        if (rx_done_f) begin
            done_cnt_f++;
            byte_last_f = rx_byte_f;
            done_cyc_f  = cyc;
        end
        if (rx_frame_err_f)  ferr_cnt_f++;
        if (rx_parity_err_f) perr_total++;
        if ($countones(cur) > 1 || $countones(cur_f) > 1) excl_viol++;
        if (|(cur & prev_p) || |(cur_f & prev_p_f)) width_viol++;
        prev_p   = cur;
        prev_p_f = cur_f;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic clear_counts();
        done_cnt   = 0;
        ferr_cnt   = 0;
        perr_cnt   = 0;
        done_cyc   = -1;
        done_cnt_f = 0;
        ferr_cnt_f = 0;
        done_cyc_f = -1;
        byteq.delete();
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx   = 1'b1;
        rx_f = 1'b1;
        wait_cycles(n);
    endtask

    task automatic send_bit(input bit sel, input logic v, input int cpb);
        if (sel) rx_f = v;
        else     rx   = v;
        wait_cycles(cpb);
    endtask

    // bad_par inverts the even-parity bit; it has no effect in a build without parity.
    task automatic send_frame(input bit sel, input logic [7:0] b, input logic bad_par,
                              input logic stop_v);
        int   cpb;
        logic p;
        cpb = sel ? CPB_F : CPB;
        p   = (^b) ^ bad_par;
        if (sel) start_cyc_f = cyc + 1;
        else     start_cyc   = cyc + 1;
        send_bit(sel, 1'b0, cpb);
        for (int i = 0; i < 8; i++) send_bit(sel, b[i], cpb);
`ifdef UART_RX_PARITY_EN
        send_bit(sel, p, cpb);
`endif
        send_bit(sel, stop_v, cpb);
    endtask

    initial begin
        int lat;
        rst  = 1'b1;
        rx   = 1'b1;
        rx_f = 1'b1;
        clear_counts();
        wait_cycles(3);
        check("rst_byte",   32'(rx_byte), 32'h00);
        check("rst_done",   32'(rx_done), 0);
        check("rst_active", 32'(rx_active), 0);
        check("rst_ferr",   32'(rx_frame_err), 0);
        check("rst_perr",   32'(rx_parity_err), 0);
        check("rst_active_full", 32'(rx_active_f), 0);
        rst = 1'b0;
        idle(10);

        // 0x55 at the default bit rate: one pulse, reference latency.
        clear_counts();
        send_frame(1'b1, 8'h55, 1'b0, 1'b1);
        idle(10);
        check("full_done_cnt", 32'(done_cnt_f), 1);
        check("full_byte",     32'(byte_last_f), 32'h55);
        check("full_latency",  32'(done_cyc_f - start_cyc_f), 32'(LAT_F));

        // 200-cycle low glitch at the default rate is rejected at the start-bit sample.
        clear_counts();
        rx_f = 1'b0;
        wait_cycles(100);
        check("glitch_full_active_mid", 32'(rx_active_f), 1);
        wait_cycles(100);
        rx_f = 1'b1;
        wait_cycles(435);
        check("glitch_full_active_end", 32'(rx_active_f), 0);
        check("glitch_full_done", 32'(done_cnt_f), 0);
        check("glitch_full_ferr", 32'(ferr_cnt_f), 0);

        // Short glitch on the fast instance.
        clear_counts();
        rx = 1'b0;
        wait_cycles(4);
        check("glitch_active_mid", 32'(rx_active), 1);
        wait_cycles(4);
        idle(30);
        check("glitch_active_end", 32'(rx_active), 0);
        check("glitch_done", 32'(done_cnt + ferr_cnt), 0);

        // 0x00..0x0F back to back with no idle gap.
        clear_counts();
        lat = -1;
        for (int i = 0; i < 16; i++) begin
            send_frame(1'b0, 8'(i), 1'b0, 1'b1);
            if (i == 0) lat = done_cyc - start_cyc;
        end
        idle(2 * CPB);
        check("b2b_latency", 32'(lat), 32'(LAT));
        check("b2b_done_cnt", 32'(done_cnt), 16);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("b2b_byte%0d", i),
                  (byteq.size() > i) ? 32'(byteq[i]) : 32'hffff_ffff, 32'(i));
        end
        check("b2b_ferr", 32'(ferr_cnt), 0);
        check("b2b_perr", 32'(perr_cnt), 0);

        // 0xA3 with a bad stop bit, line held low as a break, then 0x3C.
        clear_counts();
        send_frame(1'b0, 8'hA3, 1'b0, 1'b0);
        rx = 1'b0;
        wait_cycles(20000);
        check("brk_byte_hold", 32'(rx_byte), 32'h0F);
        check("brk_active",    32'(rx_active), 1);
        idle(2 * CPB);
        check("brk_ferr_cnt",  32'(ferr_cnt), 1);
        check("brk_done_cnt",  32'(done_cnt), 0);
        check("brk_byte_after", 32'(rx_byte), 32'h0F);
        clear_counts();
        send_frame(1'b0, 8'h3C, 1'b0, 1'b1);
        idle(4);
        check("post_brk_done", 32'(done_cnt), 1);
        check("post_brk_byte", 32'(rx_byte), 32'h3C);

        // One-cycle reset in the middle of data bit 4 of 0xF0.
        clear_counts();
        send_bit(1'b0, 1'b0, CPB);
        for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b0, CPB);
        rx = 1'b1;
        wait_cycles(CPB / 2);
        check("rst_mid_active_before", 32'(rx_active), 1);
        rst = 1'b1;
        wait_cycles(1);
        rst = 1'b0;
        check("rst_mid_active", 32'(rx_active), 0);
        check("rst_mid_byte",   32'(rx_byte), 32'h00);
        check("rst_mid_done",   32'(rx_done), 0);
        idle(6 * CPB);
        check("rst_mid_pulses", 32'(done_cnt + ferr_cnt + perr_cnt), 0);
        send_frame(1'b0, 8'h3C, 1'b0, 1'b1);
        idle(4);
        check("post_rst_done", 32'(done_cnt), 1);
        check("post_rst_byte", 32'(rx_byte), 32'h3C);

`ifdef UART_RX_PARITY_EN
        // 0x07 with wrong parity, then with correct parity.
        clear_counts();
        send_frame(1'b0, 8'h07, 1'b1, 1'b1);
        idle(4);
        check("par_bad_perr", 32'(perr_cnt), 1);
        check("par_bad_done", 32'(done_cnt), 0);
        check("par_bad_byte", 32'(rx_byte), 32'h3C);
        clear_counts();
        send_frame(1'b0, 8'h07, 1'b0, 1'b1);
        lat = done_cyc - start_cyc;
        idle(4);
        check("par_ok_latency", 32'(lat), 32'(LAT));
        check("par_ok_done",    32'(done_cnt), 1);
        check("par_ok_byte",    32'(rx_byte), 32'h07);
        check("par_ok_perr",    32'(perr_cnt), 0);
`else
        check("no_par_perr_total", 32'(perr_total), 0);
`endif

        check("pulse_exclusive", 32'(excl_viol), 0);
        check("pulse_width",     32'(width_viol), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
